// File: rtl/hex_event_writer_mc_if.sv
// Host-memory write port: one 64-bit word per accepted mem_we/mem_ready handshake.
// The writer drives the address, data and write strobe; the host drives ready.
interface hex_event_writer_mc_if;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_we;
  logic        mem_ready;

  modport master (output mem_addr, output mem_data, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_data, input mem_we, output mem_ready);
endinterface

// File: rtl/hex_event_writer_mc.sv
// Multi-channel hex raster event writer: per-lane FIFOs are drained round-robin into
// packed 64-bit words written to a host frame buffer, with per-frame sequencing.
module hex_event_writer_mc #(
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int BUF_ENTRIES = 1024,
  parameter bit WRAP_MODE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_CH-1:0]     valid_in,
  input  logic [NUM_CH*16-1:0]  q,
  input  logic [NUM_CH*16-1:0]  r,
  input  logic [NUM_CH*8-1:0]   depth,
  input  logic [NUM_CH*8-1:0]   material,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [31:0]           buffer_base,
  hex_event_writer_mc_if.master mem,
  output logic [31:0]           events_written,
  output logic [15:0]           drop_count,
  output logic [7:0]            frame_seq,
  output logic                  buf_full,
  output logic                  idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;

  typedef struct packed {
    logic [7:0]  material;
    logic [7:0]  depth;
    logic [15:0] r;
    logic [15:0] q;
  } event_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_STOP} state_t;

  // Channel FIFOs
  event_t           fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr   [NUM_CH];
  logic [PTR_W-1:0] rd_ptr   [NUM_CH];
  logic [CNT_W-1:0] fifo_cnt [NUM_CH];
  logic [CNT_W-1:0] cnt_next [NUM_CH];
  event_t           ev_in    [NUM_CH];
  logic [NUM_CH-1:0] push, pop, drop, not_empty;
  logic              fifo_empty_next;
  logic [3:0]        drops_now;
  logic [16:0]       drop_add;

  // Arbiter and write engine
  state_t            state, state_next;
  logic [CH_W-1:0]   last_grant, grant;
  int                rr_idx;
  logic              rr_found;
  logic              any_ne, issue, complete, stop_hit, stale;
  logic [IDX_W-1:0]  index, issue_idx;
  logic [31:0]       mem_addr_q, issue_addr;
  logic [63:0]       mem_data_q, issue_word;
  logic              mem_we_q;
  event_t            head;

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_data = mem_data_q;
  assign mem.mem_we   = mem_we_q;

  // in_ready doubles as the registered "not full" status, so push/drop see the
  // occupancy as it stood at the start of the cycle.
  always_comb begin
    drops_now = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ev_in[c]     = {material[c*8 +: 8], depth[c*8 +: 8], r[c*16 +: 16], q[c*16 +: 16]};
      not_empty[c] = (fifo_cnt[c] != '0);
      push[c]      = valid_in[c] & in_ready[c];
      drop[c]      = valid_in[c] & ~in_ready[c];
      drops_now    = drops_now + {3'b000, drop[c]};
    end
  end

  assign drop_add = {1'b0, drop_count} + {13'b0, drops_now};
  assign any_ne   = |not_empty;

  always_comb begin
    fifo_empty_next = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]      = issue & (grant == CH_W'(c));
      cnt_next[c] = fifo_cnt[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      if (cnt_next[c] != '0) fifo_empty_next = 1'b0;
    end
  end

  // Round-robin: search begins at the channel after the last grant.
  always_comb begin
    grant    = last_grant;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = int'(last_grant) + i;
      if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
      if (!rr_found && not_empty[rr_idx[CH_W-1:0]]) begin
        grant    = rr_idx[CH_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign head     = fifo_mem[grant][rd_ptr[grant]];
  assign complete = mem_we_q & mem.mem_ready;
  assign stop_hit = !WRAP_MODE && !stale && (index == IDX_W'(BUF_ENTRIES - 1));

  // A back-to-back issue addresses the slot after the word completing this cycle.
  assign issue_idx  = (complete && !stale) ? index + 1'b1 : index;
  assign issue_addr = buffer_base + (32'(issue_idx) << 3);
  assign issue_word = {frame_seq, 5'b00000, 3'(grant), head};

  // NOTE: every variable written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!frame_start && any_ne) begin
          issue      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (frame_start) begin
          if (mem.mem_ready) state_next = ST_IDLE;
        end else if (mem.mem_ready) begin
          if (stop_hit)    state_next = ST_STOP;
          else if (any_ne) issue      = 1'b1;
          else             state_next = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (frame_start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        fifo_cnt[c] <= '0;
      end
      in_ready <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        fifo_cnt[c] <= cnt_next[c];
        in_ready[c] <= (cnt_next[c] != CNT_W'(FIFO_DEPTH));
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) fifo_mem[c][wr_ptr[c]] <= ev_in[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      index          <= '0;
      events_written <= '0;
      drop_count     <= '0;
      frame_seq      <= '0;
      buf_full       <= 1'b0;
      idle           <= 1'b1;
      stale          <= 1'b0;
      last_grant     <= CH_W'(NUM_CH - 1);
    end else begin
      state    <= state_next;
      mem_we_q <= (state_next == ST_ISSUE);
      idle     <= fifo_empty_next && (state_next != ST_ISSUE);
      if (issue) begin
        mem_addr_q <= issue_addr;
        mem_data_q <= issue_word;
        last_grant <= grant;
      end
      if (frame_start) begin
        index          <= '0;
        events_written <= '0;
        drop_count     <= '0;
        buf_full       <= 1'b0;
        frame_seq      <= frame_seq + 8'd1;
        // A write still pending belongs to the old frame and must not be counted.
        stale          <= mem_we_q & ~mem.mem_ready;
      end else begin
        drop_count <= drop_add[16] ? 16'hFFFF : drop_add[15:0];
        if (complete) begin
          if (stale) begin
            stale <= 1'b0;
          end else begin
            index          <= index + 1'b1;
            events_written <= events_written + 32'd1;
            if (stop_hit) buf_full <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_event_writer_mc.sv
// Self-checking bench: three instances (default, 4-entry stop, 4-entry wrap) share
// stimulus; writes are logged mid-cycle and compared against hand-computed values.
module tb_hex_event_writer_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_start, mem_ready;
  logic [3:0]  valid_in;
  logic [63:0] q_bus, r_bus;
  logic [31:0] depth_bus, mat_bus, buffer_base;

  logic [2:0][3:0]  in_ready_o;
  logic [2:0][31:0] ew_o;
  logic [2:0][15:0] dc_o;
  logic [2:0][7:0]  fs_o;
  logic [2:0]       bf_o, idle_o;

  hex_event_writer_mc_if mif_a ();
  hex_event_writer_mc_if mif_s ();
  hex_event_writer_mc_if mif_w ();
  assign mif_a.mem_ready = mem_ready;
  assign mif_s.mem_ready = mem_ready;
  assign mif_w.mem_ready = mem_ready;

  hex_event_writer_mc #(.NUM_CH(4), .FIFO_DEPTH(8), .BUF_ENTRIES(1024), .WRAP_MODE(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .valid_in(valid_in),
    .q(q_bus), .r(r_bus), .depth(depth_bus), .material(mat_bus), .in_ready(in_ready_o[0]),
    .buffer_base(buffer_base), .mem(mif_a), .events_written(ew_o[0]), .drop_count(dc_o[0]),
    .frame_seq(fs_o[0]), .buf_full(bf_o[0]), .idle(idle_o[0]));

  hex_event_writer_mc #(.NUM_CH(4), .FIFO_DEPTH(8), .BUF_ENTRIES(4), .WRAP_MODE(1'b0)) u_dut_s (
    .clk(clk), .reset(reset), .frame_start(frame_start), .valid_in(valid_in),
    .q(q_bus), .r(r_bus), .depth(depth_bus), .material(mat_bus), .in_ready(in_ready_o[1]),
    .buffer_base(buffer_base), .mem(mif_s), .events_written(ew_o[1]), .drop_count(dc_o[1]),
    .frame_seq(fs_o[1]), .buf_full(bf_o[1]), .idle(idle_o[1]));

  hex_event_writer_mc #(.NUM_CH(4), .FIFO_DEPTH(8), .BUF_ENTRIES(4), .WRAP_MODE(1'b1)) u_dut_w (
    .clk(clk), .reset(reset), .frame_start(frame_start), .valid_in(valid_in),
    .q(q_bus), .r(r_bus), .depth(depth_bus), .material(mat_bus), .in_ready(in_ready_o[2]),
    .buffer_base(buffer_base), .mem(mif_w), .events_written(ew_o[2]), .drop_count(dc_o[2]),
    .frame_seq(fs_o[2]), .buf_full(bf_o[2]), .idle(idle_o[2]));

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int          ch;
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  d;
    logic [7:0]  m;
    logic [31:0] addr;
    logic [63:0] data;
  } vec_t;

  wr_t  log_a[$], log_s[$], log_w[$];
  vec_t vecs[6];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A write completes at the next rising edge when we and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (mif_a.mem_we && mif_a.mem_ready) log_a.push_back('{mif_a.mem_addr, mif_a.mem_data, cyc});
    if (mif_s.mem_we && mif_s.mem_ready) log_s.push_back('{mif_s.mem_addr, mif_s.mem_data, cyc});
    if (mif_w.mem_we && mif_w.mem_ready) log_w.push_back('{mif_w.mem_addr, mif_w.mem_data, cyc});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic wr_t get_wr(input int which, input int i);
    wr_t w;
    w.addr = 'x;
    w.data = 'x;
    w.cyc  = -1;
    case (which)
      0: if (i < log_a.size()) w = log_a[i];
      1: if (i < log_s.size()) w = log_s[i];
      default: if (i < log_w.size()) w = log_w[i];
    endcase
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ev(input int c, input logic [15:0] qq, input logic [15:0] rr,
                        input logic [7:0] d, input logic [7:0] m);
    q_bus[c*16 +: 16]   = qq;
    r_bus[c*16 +: 16]   = rr;
    depth_bus[c*8 +: 8] = d;
    mat_bus[c*8 +: 8]   = m;
    valid_in[c]         = 1'b1;
  endtask

  task automatic push_one(input int c, input logic [15:0] qq, input logic [15:0] rr,
                          input logic [7:0] d, input logic [7:0] m);
    set_ev(c, qq, rr, d, m);
    tick(1);
    valid_in = '0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    valid_in    = '0;
    frame_start = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    log_a.delete();
    log_s.delete();
    log_w.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    wr_t w;
    vecs[0] = '{0, 16'h0003, 16'hFFFE, 8'h10, 8'h05, 32'h1000, 64'h0000_0510_FFFE_0003};
    vecs[1] = '{1, 16'hFFFF, 16'h0000, 8'hFF, 8'h00, 32'h1008, 64'h0001_00FF_0000_FFFF};
    vecs[2] = '{2, 16'h7FFF, 16'h8000, 8'h00, 8'hFF, 32'h1010, 64'h0002_FF00_8000_7FFF};
    vecs[3] = '{3, 16'h1234, 16'h5678, 8'hAB, 8'hCD, 32'h1018, 64'h0003_CDAB_5678_1234};
    vecs[4] = '{0, 16'hFF9C, 16'h0064, 8'h01, 8'h02, 32'h1020, 64'h0000_0201_0064_FF9C};
    vecs[5] = '{2, 16'h0000, 16'h0000, 8'h00, 8'h00, 32'h1028, 64'h0002_0000_0000_0000};

    q_bus = '0; r_bus = '0; depth_bus = '0; mat_bus = '0;
    buffer_base = 32'h1000;
    mem_ready   = 1'b1;
    do_reset();

    // Reset state
    check("rst_we",   mif_a.mem_we, 0);
    check("rst_addr", mif_a.mem_addr, 0);
    check("rst_data", mif_a.mem_data, 0);
    check("rst_ew",   ew_o[0], 0);
    check("rst_drop", dc_o[0], 0);
    check("rst_seq",  fs_o[0], 0);
    check("rst_full", bf_o, 0);
    check("rst_rdy",  in_ready_o, 12'hFFF);
    check("rst_idle", idle_o, 3'b111);

    // Packing and addressing, one event at a time
    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].ch, vecs[i].q, vecs[i].r, vecs[i].d, vecs[i].m);
      tick(4);
      w = get_wr(0, i);
      check($sformatf("vec%0d_addr", i), w.addr, vecs[i].addr);
      check($sformatf("vec%0d_data", i), w.data, vecs[i].data);
      check($sformatf("vec%0d_ew", i), ew_o[0], i + 1);
      check($sformatf("vec%0d_idle", i), idle_o[0], 1);
    end

    // All four channels in one cycle: round-robin from ch0, back-to-back
    do_reset();
    for (int c = 0; c < 4; c++) set_ev(c, 16'h0100 + 16'(c), 16'h0, 8'h0, 8'h0);
    tick(1);
    valid_in = '0;
    tick(8);
    check("rr_count", log_a.size(), 4);
    for (int c = 0; c < 4; c++) begin
      w = get_wr(0, c);
      check($sformatf("rr%0d_addr", c), w.addr, 32'h1000 + 32'(c * 8));
      check($sformatf("rr%0d_chan", c), w.data[50:48], c);
      check($sformatf("rr%0d_q", c), w.data[15:0], 16'h0100 + 16'(c));
      check($sformatf("rr%0d_cyc", c), w.cyc - get_wr(0, 0).cyc, c);
    end

    // Backpressure: word held stable, then FIFO overflow drops one event
    do_reset();
    mem_ready = 1'b0;
    push_one(0, 16'h0001, 16'h0002, 8'h03, 8'h04);
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("hold_we",   mif_a.mem_we, 1);
      check("hold_addr", mif_a.mem_addr, 32'h1000);
      check("hold_data", mif_a.mem_data, 64'h0000_0403_0002_0001);
      tick(1);
    end
    for (int k = 0; k < 9; k++) begin
      set_ev(0, 16'(10 + k), 16'h0, 8'h0, 8'h0);
      tick(1);
    end
    valid_in = '0;
    check("ovf_rdy",  in_ready_o[0], 4'b1110);
    check("ovf_drop", dc_o[0], 1);
    mem_ready = 1'b1;
    tick(14);
    check("drain_cnt",  log_a.size(), 9);
    check("drain_ew",   ew_o[0], 9);
    check("drain_last", get_wr(0, 8).data[15:0], 16'd17);
    check("drain_idle", idle_o[0], 1);
    check("drain_rdy",  in_ready_o[0], 4'hF);
    check("drain_drop", dc_o[0], 1);

    // Stop vs wrap at capacity (4-entry buffers), then frame_start
    do_reset();
    buffer_base = 32'h2000;
    for (int c = 0; c < 4; c++) set_ev(c, 16'(c), 16'h0, 8'h0, 8'h0);
    tick(1);
    valid_in = '0;
    set_ev(0, 16'h0010, 16'h0, 8'h0, 8'h0);
    set_ev(1, 16'h0011, 16'h0, 8'h0, 8'h0);
    tick(1);
    valid_in = '0;
    tick(10);
    check("stop_cnt",   log_s.size(), 4);
    check("stop_addr3", get_wr(1, 3).addr, 32'h2018);
    check("stop_full",  bf_o[1], 1);
    check("stop_we",    mif_s.mem_we, 0);
    check("stop_ew",    ew_o[1], 4);
    check("stop_idle",  idle_o[1], 0);
    check("wrap_cnt",   log_w.size(), 6);
    check("wrap_addr4", get_wr(2, 4).addr, 32'h2000);
    check("wrap_q4",    get_wr(2, 4).data[15:0], 16'h0010);
    check("wrap_full",  bf_o[2], 0);
    check("wrap_ew",    ew_o[2], 6);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("fs_seq",  fs_o[1], 1);
    check("fs_full", bf_o[1], 0);
    check("fs_ew",   ew_o[1], 0);
    tick(6);
    check("resume_cnt",   log_s.size(), 6);
    check("resume_addr4", get_wr(1, 4).addr, 32'h2000);
    check("resume_seq4",  get_wr(1, 4).data[63:56], 8'd1);
    check("resume_q4",    get_wr(1, 4).data[15:0], 16'h0010);
    check("resume_addr5", get_wr(1, 5).addr, 32'h2008);
    check("resume_q5",    get_wr(1, 5).data[15:0], 16'h0011);
    check("resume_ew",    ew_o[1], 2);
    check("resume_idle",  idle_o[1], 1);

    // frame_start during a pending write: it completes but is not counted
    do_reset();
    buffer_base = 32'h1000;
    mem_ready   = 1'b0;
    push_one(1, 16'h00AA, 16'h0, 8'h0, 8'h0);
    tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    mem_ready   = 1'b1;
    tick(3);
    check("stale_cnt",  log_a.size(), 1);
    check("stale_seq",  get_wr(0, 0).data[63:56], 8'd0);
    check("stale_ew",   ew_o[0], 0);
    push_one(1, 16'h00BB, 16'h0, 8'h0, 8'h0);
    tick(4);
    check("new_addr", get_wr(0, 1).addr, 32'h1000);
    check("new_seq",  get_wr(0, 1).data[63:56], 8'd1);
    check("new_ew",   ew_o[0], 1);

    // Asynchronous reset in the middle of a write
    do_reset();
    mem_ready   = 1'b0;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    push_one(2, 16'h0055, 16'h0, 8'h0, 8'h0);
    tick(1);
    check("pre_rst_we",  mif_a.mem_we, 1);
    check("pre_rst_seq", fs_o[0], 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_we",   mif_a.mem_we, 0);
    check("arst_addr", mif_a.mem_addr, 0);
    check("arst_data", mif_a.mem_data, 0);
    check("arst_seq",  fs_o[0], 0);
    check("arst_rdy",  in_ready_o[0], 4'hF);
    check("arst_idle", idle_o[0], 1);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("post_rst_cnt", log_a.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_event_writer_mc.md
# hex_event_writer_mc

Multi-channel, parametrised host-memory writer for hexagonal raster events. Up to NUM_CH rasterizer lanes each push (q, r, depth, material) events into a private FIFO. A round-robin arbiter drains the FIFOs into packed 64-bit words written to a host frame buffer over a ready-handshaked port. Adds per-frame sequencing, drop accounting and a selectable wrap/stop policy at buffer capacity. It sits between the hexagonal rasterizer lanes and the host memory interface in the GPU system top.

## Interface
- NUM_CH, 4: number of input channels (1..8)
- FIFO_DEPTH, 8: entries per channel FIFO (power of two, ≥2)
- BUF_ENTRIES, 1024: 64-bit words in the host buffer (power of two)
- WRAP_MODE, 1: 1 = index wraps to 0 at capacity; 0 = stop and raise buf_full
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  one-cycle pulse, begins a new frame
- valid_in  in  NUM_CH  per-channel event strobe
- q  in  NUM_CH×16  signed axial q per channel
- r  in  NUM_CH×16  signed axial r per channel
- depth  in  NUM_CH×8  per-channel depth
- material  in  NUM_CH×8  per-channel material id
- in_ready  out  NUM_CH  FIFO not full (registered status)
- buffer_base  in  32  byte base address of host buffer
- mem_addr  out  32  write byte address
- mem_data  out  64  packed event word
- mem_we  out  1  write request
- mem_ready  in  1  host accepts write when high with mem_we
- events_written  out  32  words completed this frame
- drop_count  out  16  events dropped this frame, saturating
- frame_seq  out  8  frame counter
- buf_full  out  1  WRAP_MODE=0 and buffer exhausted
- idle  out  1  all FIFOs empty and no write pending

## Operation
- Push: valid_in[c] while FIFO c full (status at cycle start) → event dropped, drop_count += 1 (saturates at 0xFFFF); simultaneous pop does not rescue it. Multiple channels dropping in one cycle add their count.
- Packing: [15:0] q, [31:16] r, [39:32] depth, [47:40] material, [50:48] channel id, [55:51] zero, [63:56] frame_seq.
- Address: buffer_base + {index, 3'b000}; index is log2(BUF_ENTRIES) bits, latched at issue.
- States: IDLE, ISSUE, STOP.
  - IDLE: any FIFO non-empty → grant, pop, load mem_addr/mem_data, mem_we=1, → ISSUE.
  - ISSUE: hold addr/data/we until mem_ready=1. On completion: index+1, events_written+1; if another FIFO non-empty and no stop condition, pop next and stay in ISSUE (mem_we stays high); else → IDLE (mem_we=0).
  - Stop condition: WRAP_MODE=0 and completed index == BUF_ENTRIES-1 → STOP, buf_full=1; FIFOs keep filling/dropping, nothing issued.
  - WRAP_MODE=1: index BUF_ENTRIES-1 +1 → 0, no flag.
- Arbiter: round-robin, search starts at channel after last grant; after reset last grant = NUM_CH-1 (ch0 first).
- frame_start: next cycle index=0, events_written=0, drop_count=0, buf_full=0, frame_seq+1 (wraps 255→0); STOP → IDLE. An in-flight write keeps its latched address/data and completes normally but is not counted in the new frame. FIFOs are not flushed. frame_start coincident with completion: frame_start wins (index=0, count=0).
- reset mid-write: mem_we drops immediately (async); the transaction is abandoned.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_data=0, events_written=0, drop_count=0, frame_seq=0, buf_full=0, in_ready=all 1, idle=1, state IDLE.
- Latency: event pushed at edge t → mem_we=1 after edge t+1 (1 cycle, empty system).
- Throughput: 1 word/cycle with mem_ready held high.
- in_ready, buf_full, idle are registered; counters update the edge after the event.

## Test plan
- Single event ch0 q=3, r=-2, depth=0x10, mat=5, base=0x1000, ready=1 → one write addr 0x1000, data 0x00000005_10FFFE0003, events_written=1, idle=1.
- All 4 channels valid in one cycle, ready=1 → four writes in order ch0,1,2,3 at 0x1000..0x1018 on consecutive cycles.
- ready held low 5 cycles → addr/data/we stable; 9 further pushes on one channel → 1 drop (FIFO holds 8), in_ready=0, drop_count=1.
- WRAP_MODE=0, BUF_ENTRIES=4, 6 events → 4 writes, buf_full=1, no mem_we; frame_start → index 0, frame_seq=1, remaining 2 written at base with data[63:56]=1.
- WRAP_MODE=1, BUF_ENTRIES=4, 5 events → 5th at buffer_base, buf_full=0.
- reset asserted while mem_we=1 → mem_we=0 same cycle, all outputs at reset values.
